// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive front end: FSM state encoding,
// capture floors for the configuration inputs, and where the bit samples sit
// relative to the middle of the bit.
package uart_rx_pkg;

    // The state is kept as a plain one-bit vector so older blocks can use it.
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    // Smallest configuration values accepted when a frame starts.
    localparam int PRESCALE_MIN   = 8;
    localparam int FRAME_BITS_MIN = 2;

    // Tick offsets relative to H = P/2, where P is the oversample ratio.
    localparam int SAMPLE_OFS_EARLY = -1;
    localparam int SAMPLE_OFS_MID   = 0;
    localparam int SAMPLE_OFS_LATE  = 1;
    localparam int VALID_OFS        = 2;

    // Two-out-of-three vote.
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage : uart_rx_pkg

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line. Both flops reset to
// 1, the idle level of the line, so reset never looks like a start edge.
module uart_rx_sync (
    input  logic UCLK,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Shift the line through two flops to settle any metastability.
    always_ff @(posedge UCLK or negedge reset) begin
        if (!reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments keep this a two-stage shift;
            // with blocking ones both flops would take d_i in the same edge.
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule : uart_rx_sync

// File: rtl/uart_rx_data_sampler.sv
// Oversampling front end of the UART receiver. It synchronises RX_IN, finds
// the falling edge of the start bit, counts ticks within each bit and bits
// within the frame, and samples each bit around its middle.
// Build option RX_MAJORITY_VOTE_EN: when defined, each bit is a majority vote
// of the samples at ticks H-1, H and H+1. When it is not defined, the bit is
// the single sample at tick H. In both builds sample_valid rises at tick H+2.
module uart_rx_data_sampler
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_W = 6,
    parameter int BITCNT_W   = 4
) (
    input  logic                  UCLK,
    input  logic                  reset,
    input  logic                  rx_en,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [BITCNT_W-1:0]   frame_bits,
    output logic                  sampled_bit,
    output logic                  sample_valid,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [BITCNT_W-1:0]   bit_cnt,
    output logic                  busy,
    output logic                  frame_done
);

    // The last sample is taken from the live line one tick before the
    // registered strobe appears.
    localparam int VOTE_OFS = VALID_OFS - 1;

    logic                  rx_s;
    logic                  rx_prev_q;
    logic                  start_edge;

    logic [0:0]            state_q,        state_d;
    logic [PRESCALE_W-1:0] edge_cnt_q,     edge_cnt_d;
    logic [BITCNT_W-1:0]   bit_cnt_q,      bit_cnt_d;
    logic [PRESCALE_W-1:0] prescale_q,     prescale_d;
    logic [BITCNT_W-1:0]   frame_bits_q,   frame_bits_d;
    logic                  sampled_bit_q,  sampled_bit_d;
    logic                  sample_valid_q, sample_valid_d;
    logic                  frame_done_q,   frame_done_d;

    logic [PRESCALE_W-1:0] half;
    int                    half_i;
    int                    edge_i;
    logic                  at_mid;
    logic                  at_vote;
    logic                  last_tick;
    logic                  last_bit;
    logic                  false_start;
    logic                  s_mid_q;
    logic                  vote;

    // An even ratio of at least 8 keeps H-1..H+2 inside the bit.
    function automatic logic [PRESCALE_W-1:0] clamp_prescale(input logic [PRESCALE_W-1:0] p);
        logic [PRESCALE_W-1:0] p_even;
        p_even = {p[PRESCALE_W-1:1], 1'b0};
        if (int'(p_even) < PRESCALE_MIN) begin
            return PRESCALE_W'(PRESCALE_MIN);
        end
        return p_even;
    endfunction

    // A frame needs at least a start bit and a stop bit.
    function automatic logic [BITCNT_W-1:0] clamp_frame_bits(input logic [BITCNT_W-1:0] f);
        if (int'(f) < FRAME_BITS_MIN) begin
            return BITCNT_W'(FRAME_BITS_MIN);
        end
        return f;
    endfunction

    uart_rx_sync u_rx_sync (
        .UCLK  (UCLK),
        .reset (reset),
        .d_i   (RX_IN),
        .q_o   (rx_s)
    );

    // Delay the synchronised line by one cycle to detect a falling edge.
    always_ff @(posedge UCLK or negedge reset) begin
        if (!reset) begin
            rx_prev_q <= 1'b1;
        end else begin
            rx_prev_q <= rx_s;
        end
    end

    assign start_edge = rx_prev_q & ~rx_s;

    assign half      = {1'b0, prescale_q[PRESCALE_W-1:1]};
    assign half_i    = int'(half);
    assign edge_i    = int'(edge_cnt_q);
    assign at_mid    = (edge_i == half_i + SAMPLE_OFS_MID);
    assign at_vote   = (edge_i == half_i + VOTE_OFS);
    assign last_tick = (edge_cnt_q == prescale_q - PRESCALE_W'(1));
    assign last_bit  = (bit_cnt_q == frame_bits_q - BITCNT_W'(1));

    // A start bit that votes high was noise. Its strobe has already gone
    // out, so the checker downstream can flag it. The frame is then dropped.
    assign false_start = sample_valid_q && (bit_cnt_q == '0) && sampled_bit_q;

    // Capture the sample at tick H.
    always_ff @(posedge UCLK or negedge reset) begin
        if (!reset) begin
            s_mid_q <= 1'b1;
        end else if (state_q == ST_ACTIVE && at_mid) begin
            s_mid_q <= rx_s;
        end
    end

`ifdef RX_MAJORITY_VOTE_EN
    logic s_early_q;
    logic at_early;

    assign at_early = (edge_i == half_i + SAMPLE_OFS_EARLY);

    // Capture the sample at tick H-1. The tick H+1 sample is read from the
    // live line in the vote cycle.
    always_ff @(posedge UCLK or negedge reset) begin
        if (!reset) begin
            s_early_q <= 1'b1;
        end else if (state_q == ST_ACTIVE && at_early) begin
            s_early_q <= rx_s;
        end
    end

    assign vote = majority3(s_early_q, s_mid_q, rx_s);
`else
    assign vote = s_mid_q;
`endif

    // Next state of the frame FSM, the counters and the output strobes.
    always_comb begin
        // NOTE: every signal gets its default value first. Otherwise a path
        // through the case could leave a signal unassigned and infer a latch.
        state_d        = state_q;
        edge_cnt_d     = edge_cnt_q;
        bit_cnt_d      = bit_cnt_q;
        prescale_d     = prescale_q;
        frame_bits_d   = frame_bits_q;
        sampled_bit_d  = sampled_bit_q;
        sample_valid_d = 1'b0;
        frame_done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                edge_cnt_d = '0;
                bit_cnt_d  = '0;
                if (rx_en && start_edge) begin
                    // The cycle that sees the edge is tick 0 of the start bit.
                    state_d      = ST_ACTIVE;
                    edge_cnt_d   = PRESCALE_W'(1);
                    prescale_d   = clamp_prescale(prescale);
                    frame_bits_d = clamp_frame_bits(frame_bits);
                end
            end
            default: begin
                if (!rx_en || false_start) begin
                    state_d    = ST_IDLE;
                    edge_cnt_d = '0;
                    bit_cnt_d  = '0;
                end else if (last_tick) begin
                    edge_cnt_d = '0;
                    if (last_bit) begin
                        state_d      = ST_IDLE;
                        bit_cnt_d    = '0;
                        frame_done_d = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BITCNT_W'(1);
                    end
                end else begin
                    edge_cnt_d = edge_cnt_q + PRESCALE_W'(1);
                    if (at_vote) begin
                        sampled_bit_d  = vote;
                        sample_valid_d = 1'b1;
                    end
                end
            end
        endcase
    end

    // Register the state, the counters, the captured configuration and the outputs.
    always_ff @(posedge UCLK or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            edge_cnt_q     <= '0;
            bit_cnt_q      <= '0;
            prescale_q     <= PRESCALE_W'(PRESCALE_MIN);
            frame_bits_q   <= BITCNT_W'(FRAME_BITS_MIN);
            sampled_bit_q  <= 1'b1;
            sample_valid_q <= 1'b0;
            frame_done_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            edge_cnt_q     <= edge_cnt_d;
            bit_cnt_q      <= bit_cnt_d;
            prescale_q     <= prescale_d;
            frame_bits_q   <= frame_bits_d;
            sampled_bit_q  <= sampled_bit_d;
            sample_valid_q <= sample_valid_d;
            frame_done_q   <= frame_done_d;
        end
    end

    assign sampled_bit  = sampled_bit_q;
    assign sample_valid = sample_valid_q;
    assign edge_cnt     = edge_cnt_q;
    assign bit_cnt      = bit_cnt_q;
    assign busy         = (state_q == ST_ACTIVE);
    assign frame_done   = frame_done_q;

endmodule : uart_rx_data_sampler
